// File: rtl/padded_frame_loader_pkg.sv
// Shared types and frame geometry for the padded frame loader.
// Localparams describe the default 64x64 image; helpers recompute them for other sizes.
package padded_frame_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BORDER,
        ST_LOAD,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_TOP,
        PH_BOTTOM,
        PH_SIDES
    } border_phase_t;

    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;

    function automatic int padded_dim(input int n);
        return n + 2;
    endfunction

    function automatic int border_cycles(input int img_w, input int img_h);
        return 2 * padded_dim(img_w) + 2 * img_h;
    endfunction

    function automatic int frame_pixels(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    localparam int PW            = padded_dim(DEF_IMG_W);
    localparam int PH            = padded_dim(DEF_IMG_H);
    localparam int BORDER_CYCLES = border_cycles(DEF_IMG_W, DEF_IMG_H);
    localparam int FRAME_PIXELS  = frame_pixels(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/padded_frame_loader_if.sv
// Pixel stream handshake plus the row/col write port into the padded frame buffer.
// slave = the loader; master = stream source and buffer memory.
interface padded_frame_loader_if #(
    parameter int PIX_W = 8,
    parameter int AW    = 7
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_pixel;
    logic             s_last;

    logic             mem_we;
    logic [AW-1:0]    mem_row;
    logic [AW-1:0]    mem_col;
    logic [PIX_W-1:0] mem_wdata;

    modport master (
        output s_valid, s_pixel, s_last,
        input  s_ready, mem_we, mem_row, mem_col, mem_wdata
    );

    modport slave (
        input  s_valid, s_pixel, s_last,
        output s_ready, mem_we, mem_row, mem_col, mem_wdata
    );
endinterface

// File: rtl/padded_frame_loader_border_addr_gen.sv
// Walks the one-pixel border of the padded frame: top row, bottom row, then (r,0),(r,PW-1)
// for each interior row. `last` flags the final border cell.
module border_addr_gen
    import padded_frame_loader_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] row,
    output logic [AW-1:0] col,
    output logic          last
);
    localparam logic [AW-1:0] COL_END  = AW'(padded_dim(IMG_W) - 1);
    localparam logic [AW-1:0] ROW_BOT  = AW'(padded_dim(IMG_H) - 1);
    localparam logic [AW-1:0] ROW_SIDE = AW'(IMG_H);

    border_phase_t phase;

    assign last = (phase == PH_SIDES) && (row == ROW_SIDE) && (col == COL_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_TOP;
            row   <= '0;
            col   <= '0;
        end else if (clear) begin
            phase <= PH_TOP;
            row   <= '0;
            col   <= '0;
        end else if (advance) begin
            unique case (phase)
                PH_TOP: begin
                    if (col == COL_END) begin
                        col   <= '0;
                        row   <= ROW_BOT;
                        phase <= PH_BOTTOM;
                    end else begin
                        col <= col + AW'(1);
                    end
                end
                PH_BOTTOM: begin
                    if (col == COL_END) begin
                        col   <= '0;
                        row   <= AW'(1);
                        phase <= PH_SIDES;
                    end else begin
                        col <= col + AW'(1);
                    end
                end
                PH_SIDES: begin
                    // Left edge then right edge of each interior row.
                    if (col == '0) begin
                        col <= COL_END;
                    end else begin
                        col <= '0;
                        row <= row + AW'(1);
                    end
                end
                default: phase <= PH_TOP;
            endcase
        end
    end
endmodule

// File: rtl/padded_frame_loader.sv
// Clears the border of a zero-padded frame buffer, then writes a raster pixel stream
// into its interior and pulses frame_done when the buffer is ready for window reads.
module padded_frame_loader
    import padded_frame_loader_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8,
    parameter int AW    = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    padded_frame_loader_if.slave  bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_last
);
    localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 1);
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);

    state_t        state;
    logic [AW-1:0] pix_r;
    logic [AW-1:0] pix_c;
    logic [AW-1:0] b_row;
    logic [AW-1:0] b_col;
    logic          b_last;
    logic          pix_final;
    logic          accept;

    assign pix_final = (pix_r == ROW_LAST) && (pix_c == COL_LAST);
    assign accept    = bus.s_valid && bus.s_ready;

    border_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_border (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ST_IDLE),
        .advance (state == ST_BORDER),
        .row     (b_row),
        .col     (b_col),
        .last    (b_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pix_r         <= '0;
            pix_c         <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err_last      <= 1'b0;
            bus.s_ready   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_row   <= '0;
            bus.mem_col   <= '0;
            bus.mem_wdata <= '0;
        end else begin
            frame_done <= 1'b0;
            bus.mem_we <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_BORDER;
                        busy     <= 1'b1;
                        err_last <= 1'b0;
                        pix_r    <= '0;
                        pix_c    <= '0;
                    end
                end
                ST_BORDER: begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_row   <= b_row;
                    bus.mem_col   <= b_col;
                    bus.mem_wdata <= '0;
                    if (b_last) begin
                        state       <= ST_LOAD;
                        bus.s_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_row   <= pix_r + AW'(1);
                        bus.mem_col   <= pix_c + AW'(1);
                        bus.mem_wdata <= bus.s_pixel;
                        // Either an s_last or the final raster index ends the frame;
                        // disagreement between the two is a framing error.
                        if (bus.s_last || pix_final) begin
                            bus.s_ready <= 1'b0;
                            err_last    <= bus.s_last != pix_final;
                            state       <= ST_DONE;
                        end else if (pix_c == COL_LAST) begin
                            pix_c <= '0;
                            pix_r <= pix_r + AW'(1);
                        end else begin
                            pix_c <= pix_c + AW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_padded_frame_loader.sv
// Directed bench for padded_frame_loader at the default 64x64 geometry.
module tb_padded_frame_loader;
    import padded_frame_loader_pkg::*;

    localparam int W = DEF_IMG_W;
    localparam int H = DEF_IMG_H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done, err_last;

    padded_frame_loader_if #(.PIX_W(8), .AW(7)) bus ();

    padded_frame_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .AW(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .err_last   (err_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] img [0:PH-1][0:PW-1];
    int         wcnt[0:PH-1][0:PW-1];
    int         exp_r[0:BORDER_CYCLES-1];
    int         exp_c[0:BORDER_CYCLES-1];

    int   b_we, b_bad, b_gap, b_ready_bad;
    logic b_busy_after, b_err_after, b_ready_after;
    int   l_acc, l_we, l_bad, l_ready_low, l_done_off, l_done_cnt, l_busy_tail;
    logic l_ready_k1, l_err;
    bit   l_timeout;

    task automatic build_border_order();
        int n = 0;
        for (int c = 0; c < PW; c++) begin exp_r[n] = 0;      exp_c[n] = c; n++; end
        for (int c = 0; c < PW; c++) begin exp_r[n] = PH - 1; exp_c[n] = c; n++; end
        for (int r = 1; r <= H; r++) begin
            exp_r[n] = r; exp_c[n] = 0;      n++;
            exp_r[n] = r; exp_c[n] = PW - 1; n++;
        end
    endtask

    task automatic clear_img();
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++) begin
                img[r][c]  = 8'hxx;
                wcnt[r][c] = 0;
            end
    endtask

    // Border cells once with zero; interior raster index < n_interior once with index&0xFF.
    function automatic int img_errors(input int n_interior);
        int errs = 0;
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++) begin
                int exp_cnt;
                logic [7:0] exp_d;
                if (r == 0 || r == PH - 1 || c == 0 || c == PW - 1) begin
                    exp_cnt = 1; exp_d = 8'h00;
                end else begin
                    int idx = (r - 1) * W + (c - 1);
                    exp_cnt = (idx < n_interior) ? 1 : 0;
                    exp_d = 8'(idx);
                end
                if (wcnt[r][c] != exp_cnt) errs++;
                else if (exp_cnt == 1 && img[r][c] !== exp_d) errs++;
            end
        return errs;
    endfunction

    task automatic start_and_border();
        clear_img();
        b_we = 0; b_bad = 0; b_gap = 0; b_ready_bad = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        b_busy_after = busy;
        b_err_after  = err_last;
        if (bus.mem_we) b_bad++;
        for (int k = 0; k < 400 && b_we < BORDER_CYCLES; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                if (bus.mem_row !== 7'(exp_r[b_we]) || bus.mem_col !== 7'(exp_c[b_we]) ||
                    bus.mem_wdata !== 8'h00) b_bad++;
                if (b_we < BORDER_CYCLES - 1 && bus.s_ready) b_ready_bad++;
                if (bus.mem_row < 7'(PH) && bus.mem_col < 7'(PW)) begin
                    img[bus.mem_row][bus.mem_col] = bus.mem_wdata;
                    wcnt[bus.mem_row][bus.mem_col]++;
                end else b_bad++;
                b_we++;
            end else b_gap++;
        end
        b_ready_after = bus.s_ready;
    endtask

    task automatic observe_write(inout bit pend, input logic [6:0] er, input logic [6:0] ec,
                                 input logic [7:0] ed);
        if (bus.mem_we) begin
            l_we++;
            if (!pend || bus.mem_row !== er || bus.mem_col !== ec || bus.mem_wdata !== ed) l_bad++;
            if (bus.mem_row < 7'(PH) && bus.mem_col < 7'(PW)) begin
                img[bus.mem_row][bus.mem_col] = bus.mem_wdata;
                wcnt[bus.mem_row][bus.mem_col]++;
            end
        end else if (pend) l_bad++;
        pend = 0;
    endtask

    // Streams pixels idx&0xFF; last_idx<0 means s_last is never raised.
    task automatic run_load(input int last_idx, input int valid_pct, input int glitch_idx,
                            input int rst_idx);
        int idx = 0;
        bit pend = 0, fin = 0, v;
        logic [6:0] er = '0, ec = '0;
        logic [7:0] ed = '0;
        l_acc = 0; l_we = 0; l_bad = 0; l_ready_low = 0; l_done_off = 0; l_done_cnt = 0;
        l_busy_tail = 0; l_ready_k1 = 1'bx; l_err = 1'bx;
        for (int k = 0; k < 20000 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            observe_write(pend, er, ec, ed);
            if (idx == rst_idx) begin
                rst_n = 1'b0;
                bus.s_valid = 1'b0;
                #1;
                return;
            end
            if (!bus.s_ready) l_ready_low++;
            v = ($urandom_range(0, 99) < valid_pct);
            bus.s_valid = v;
            bus.s_pixel = v ? 8'(idx) : ~8'(idx);
            bus.s_last  = v ? (idx == last_idx) : 1'b1;
            if (idx == glitch_idx) start = 1'b1;
            if (v && bus.s_ready) begin
                pend = 1;
                er = 7'(idx / W + 1); ec = 7'(idx % W + 1); ed = 8'(idx);
                l_acc++;
                fin = (idx == last_idx) || (idx == W * H - 1);
                idx++;
            end
        end
        l_timeout = !fin;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            observe_write(pend, er, ec, ed);
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            start = 1'b0;
            if (k == 1) l_ready_k1 = bus.s_ready;
            if (frame_done) begin
                l_done_cnt++;
                if (l_done_off == 0) l_done_off = k;
            end
            if (k >= 2 && busy) l_busy_tail++;
        end
        l_err = err_last;
    endtask

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, frame_done, err_last, bus.s_ready, bus.mem_we} !== 5'b0 ||
            bus.mem_row !== 7'd0 || bus.mem_col !== 7'd0 || bus.mem_wdata !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b rdy=%b we=%b row=%0d col=%0d wd=%0d expected all 0",
                     busy, frame_done, err_last, bus.s_ready, bus.mem_we, bus.mem_row, bus.mem_col, bus.mem_wdata);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_we || busy || bus.s_ready || frame_done) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL idle_quiet got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_border();
        start_and_border();
        checks++;
        if (b_busy_after !== 1'b1) begin failures++; $display("FAIL busy_after_start got %b expected 1", b_busy_after); end
        checks++;
        if (b_we !== BORDER_CYCLES) begin failures++; $display("FAIL border_writes got %0d expected %0d", b_we, BORDER_CYCLES); end
        checks++;
        if (b_bad !== 0) begin failures++; $display("FAIL border_order got %0d bad writes expected 0", b_bad); end
        checks++;
        if (b_gap !== 0) begin failures++; $display("FAIL border_gaps got %0d expected 0", b_gap); end
        checks++;
        if (b_ready_bad !== 0) begin failures++; $display("FAIL border_ready got %0d ready cycles expected 0", b_ready_bad); end
        checks++;
        if (img_errors(0) !== 0) begin failures++; $display("FAIL border_cells got %0d bad cells expected 0", img_errors(0)); end
        checks++;
        if (b_ready_after !== 1'b1) begin failures++; $display("FAIL load_ready got %b expected 1", b_ready_after); end
    endtask

    task automatic test_full_frame();
        run_load(W * H - 1, 100, -1, -1);
        checks++;
        if (l_timeout || l_acc !== W * H) begin failures++; $display("FAIL full_accepts got %0d expected %0d", l_acc, W * H); end
        checks++;
        if (l_bad !== 0 || l_we !== W * H) begin failures++; $display("FAIL full_writes got we=%0d bad=%0d expected we=%0d bad=0", l_we, l_bad, W * H); end
        checks++;
        if (l_ready_k1 !== 1'b0) begin failures++; $display("FAIL full_ready_drop got %b expected 0", l_ready_k1); end
        checks++;
        if (l_done_off !== 2 || l_done_cnt !== 1) begin failures++; $display("FAIL full_done got off=%0d cnt=%0d expected off=2 cnt=1", l_done_off, l_done_cnt); end
        checks++;
        if (l_busy_tail !== 0) begin failures++; $display("FAIL full_busy_after got %0d expected 0", l_busy_tail); end
        checks++;
        if (l_err !== 1'b0) begin failures++; $display("FAIL full_err got %b expected 0", l_err); end
        checks++;
        if (img_errors(W * H) !== 0) begin failures++; $display("FAIL full_image got %0d bad cells expected 0", img_errors(W * H)); end
    endtask

    task automatic test_gaps();
        start_and_border();
        run_load(W * H - 1, 70, -1, -1);
        checks++;
        if (l_timeout || l_acc !== W * H) begin failures++; $display("FAIL gaps_accepts got %0d expected %0d", l_acc, W * H); end
        checks++;
        if (l_bad !== 0 || l_we !== W * H) begin failures++; $display("FAIL gaps_writes got we=%0d bad=%0d expected we=%0d bad=0", l_we, l_bad, W * H); end
        checks++;
        if (l_ready_low !== 0) begin failures++; $display("FAIL gaps_ready got %0d low cycles expected 0", l_ready_low); end
        checks++;
        if (img_errors(W * H) !== 0) begin failures++; $display("FAIL gaps_image got %0d bad cells expected 0", img_errors(W * H)); end
        checks++;
        if (l_done_cnt !== 1 || l_err !== 1'b0) begin failures++; $display("FAIL gaps_done got cnt=%0d err=%b expected cnt=1 err=0", l_done_cnt, l_err); end
    endtask

    task automatic test_early_last();
        start_and_border();
        run_load(100, 100, -1, -1);
        checks++;
        if (l_acc !== 101 || l_we !== 101 || l_bad !== 0) begin failures++; $display("FAIL early_writes got acc=%0d we=%0d bad=%0d expected 101/101/0", l_acc, l_we, l_bad); end
        checks++;
        if (l_err !== 1'b1) begin failures++; $display("FAIL early_err got %b expected 1", l_err); end
        checks++;
        if (l_done_off !== 2 || l_done_cnt !== 1) begin failures++; $display("FAIL early_done got off=%0d cnt=%0d expected off=2 cnt=1", l_done_off, l_done_cnt); end
        checks++;
        if (img_errors(101) !== 0) begin failures++; $display("FAIL early_image got %0d bad cells expected 0", img_errors(101)); end
    endtask

    task automatic test_missing_last();
        start_and_border();
        checks++;
        if (b_err_after !== 1'b0) begin failures++; $display("FAIL err_clear_on_start got %b expected 0", b_err_after); end
        run_load(-1, 100, -1, -1);
        checks++;
        if (l_acc !== W * H || l_bad !== 0) begin failures++; $display("FAIL nolast_accepts got acc=%0d bad=%0d expected %0d/0", l_acc, l_bad, W * H); end
        checks++;
        if (l_err !== 1'b1 || l_ready_k1 !== 1'b0) begin failures++; $display("FAIL nolast_err got err=%b rdy=%b expected err=1 rdy=0", l_err, l_ready_k1); end
        checks++;
        if (l_done_cnt !== 1) begin failures++; $display("FAIL nolast_done got %0d expected 1", l_done_cnt); end
    endtask

    task automatic test_start_in_load();
        start_and_border();
        run_load(W * H - 1, 100, 50, -1);
        checks++;
        if (l_acc !== W * H || l_we !== W * H || l_bad !== 0) begin failures++; $display("FAIL glitch_writes got acc=%0d we=%0d bad=%0d expected %0d/%0d/0", l_acc, l_we, l_bad, W * H, W * H); end
        checks++;
        if (l_done_cnt !== 1 || l_busy_tail !== 0 || l_err !== 1'b0) begin failures++; $display("FAIL glitch_done got cnt=%0d busy=%0d err=%b expected 1/0/0", l_done_cnt, l_busy_tail, l_err); end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        start_and_border();
        run_load(W * H - 1, 100, -1, 2000);
        checks++;
        if ({busy, frame_done, err_last, bus.s_ready, bus.mem_we} !== 5'b0 ||
            bus.mem_row !== 7'd0 || bus.mem_col !== 7'd0 || bus.mem_wdata !== 8'd0) begin
            failures++;
            $display("FAIL midreset_outputs got busy=%b done=%b rdy=%b we=%b row=%0d col=%0d wd=%0d expected all 0",
                     busy, frame_done, bus.s_ready, bus.mem_we, bus.mem_row, bus.mem_col, bus.mem_wdata);
        end
        checks++;
        if (l_acc !== 2000) begin failures++; $display("FAIL midreset_accepts got %0d expected 2000", l_acc); end
        repeat (3) begin @(negedge clk); if (frame_done || busy) done_seen++; end
        rst_n = 1'b1;
        repeat (5) begin @(negedge clk); if (frame_done || busy) done_seen++; end
        checks++;
        if (done_seen !== 0) begin failures++; $display("FAIL midreset_done got %0d active cycles expected 0", done_seen); end
    endtask

    task automatic test_restart();
        start_and_border();
        checks++;
        if (b_we !== BORDER_CYCLES || b_bad !== 0 || b_gap !== 0) begin failures++; $display("FAIL restart_border got we=%0d bad=%0d gap=%0d expected %0d/0/0", b_we, b_bad, b_gap, BORDER_CYCLES); end
        run_load(W * H - 1, 100, -1, -1);
        checks++;
        if (img_errors(W * H) !== 0 || l_done_cnt !== 1 || l_err !== 1'b0) begin failures++; $display("FAIL restart_frame got bad=%0d done=%0d err=%b expected 0/1/0", img_errors(W * H), l_done_cnt, l_err); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_pixel = '0;
        bus.s_last  = 1'b0;
        build_border_order();
        test_reset();
        test_border();
        test_full_frame();
        test_gaps();
        test_early_last();
        test_missing_last();
        test_start_in_load();
        test_reset_mid();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
